cc_dir_port_arb: RTL and testbench



---
 rtl/cc_dir_pkg.sv | 19 +
 rtl/cc_dir_port_arb_if.sv | 37 +++
 rtl/cc_dir_rr_arb2.sv | 23 ++
 rtl/cc_dir_port_arb.sv | 88 ++++++++
 tb/tb_cc_dir_port_arb.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cc_dir_pkg.sv
// Shared constants and types for the coherence-directory SRAM front end.
package cc_dir_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 136;
    localparam int MASK_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic REQ_CORE  = 1'b0;
    localparam logic REQ_PROBE = 1'b1;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;
endpackage

// File: rtl/cc_dir_port_arb_if.sv
// Requester handshakes, read response and SRAM RW0 pins of the directory port.
interface cc_dir_port_arb_if;
    import cc_dir_pkg::*;

    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [MASK_W-1:0] req0_wmask;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [MASK_W-1:0] req1_wmask;
    logic              resp0_valid, resp1_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en, sram_wmode;
    logic [DATA_W-1:0] sram_wdata;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_rdata, init_done,
        input  sram_addr, sram_en, sram_wmode, sram_wdata, sram_wmask,
        output sram_rdata
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_rdata, init_done,
        output sram_addr, sram_en, sram_wmode, sram_wdata, sram_wmask,
        input  sram_rdata
    );
endinterface

// File: rtl/cc_dir_rr_arb2.sv
// Two-way round-robin arbiter; the pointer always favours the loser of the last grant.
module cc_dir_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) o_gnt = r_ptr ? 2'b10 : 2'b01;
            else                o_gnt = i_req;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_ptr <= 1'b0;
        else if (|o_gnt) r_ptr <= ~o_gnt[1];
    end
endmodule

// File: rtl/cc_dir_port_arb.sv
// Directory SRAM port controller: zero-fill sweep after reset, then round-robin
// sharing of the single RW port between core and probe requesters.
module cc_dir_port_arb
    import cc_dir_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    cc_dir_port_arb_if.slave  bus
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done, r_resp0, r_resp1;
    logic [1:0]        w_gnt;
    req_t              w_req0, w_req1, w_win;
    logic              w_sram_en, w_sram_wmode;
    logic [ADDR_W-1:0] w_sram_addr;
    logic [DATA_W-1:0] w_sram_wdata;
    logic [MASK_W-1:0] w_sram_wmask;

    assign w_req0 = {bus.req0_write, bus.req0_addr, bus.req0_wdata, bus.req0_wmask};
    assign w_req1 = {bus.req1_write, bus.req1_addr, bus.req1_wdata, bus.req1_wmask};

    cc_dir_rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .i_en  (r_state == RUN),
        .i_req ({bus.req1_valid, bus.req0_valid}),
        .o_gnt (w_gnt)
    );

    // Request-to-pin path is purely combinational so a grant hits the SRAM the same cycle.
    always_comb begin
        w_win        = w_gnt[REQ_PROBE] ? w_req1 : w_req0;
        w_sram_en    = 1'b0;
        w_sram_wmode = 1'b0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        w_sram_wmask = '0;
        if (r_state == INIT) begin
            w_sram_en    = 1'b1;
            w_sram_wmode = 1'b1;
            w_sram_addr  = r_cnt;
            w_sram_wmask = '1;
        end else if (|w_gnt) begin
            w_sram_en    = 1'b1;
            w_sram_wmode = w_win.write;
            w_sram_addr  = w_win.addr;
            w_sram_wdata = w_win.wdata;
            w_sram_wmask = w_win.wmask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_resp0     <= 1'b0;
            r_resp1     <= 1'b0;
        end else begin
            r_resp0 <= w_gnt[REQ_CORE]  & ~bus.req0_write;
            r_resp1 <= w_gnt[REQ_PROBE] & ~bus.req1_write;
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN:     r_state <= RUN;
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.req0_ready  = w_gnt[REQ_CORE];
    assign bus.req1_ready  = w_gnt[REQ_PROBE];
    assign bus.resp0_valid = r_resp0;
    assign bus.resp1_valid = r_resp1;
    assign bus.resp_rdata  = bus.sram_rdata;
    assign bus.init_done   = r_init_done;
    assign bus.sram_en     = w_sram_en;
    assign bus.sram_wmode  = w_sram_wmode;
    assign bus.sram_addr   = w_sram_addr;
    assign bus.sram_wdata  = w_sram_wdata;
    assign bus.sram_wmask  = w_sram_wmask;
endmodule

// File: tb/tb_cc_dir_port_arb.sv
// Directed bench for cc_dir_port_arb with a behavioural masked SRAM on the RW0 pins.
module tb_cc_dir_port_arb;
    import cc_dir_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [DATA_W-1:0] PAT_A  = {17{8'hA5}};
    logic [DATA_W-1:0] PAT_C  = {17{8'h3C}};
    logic [DATA_W-1:0] ONES   = '1;
    logic [DATA_W-1:0] MASKED = {{119{1'b1}}, 17'b0};
    logic [DATA_W-1:0] mem [DEPTH];

    cc_dir_port_arb_if bus();
    cc_dir_port_arb dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                for (int b = 0; b < MASK_W; b++)
                    if (bus.sram_wmask[b]) mem[bus.sram_addr][b*17 +: 17] <= bus.sram_wdata[b*17 +: 17];
            end else begin
                bus.sram_rdata <= mem[bus.sram_addr];
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_wmask = '0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_wmask = '0;
    endtask

    task automatic set_req(input int id, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        if (id == 0) begin
            bus.req0_valid = 1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_wmask = m;
        end else begin
            bus.req1_valid = 1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_wmask = m;
        end
    endtask

    task automatic test_reset;
        int bad;
        idle();
        reset = 1;
        #2;
        n_cmp++; if (bus.init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: got %b want 0", bus.init_done); end
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
        n_cmp++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_resp: got %b want 00", {bus.resp1_valid, bus.resp0_valid}); end
        tick();
        reset = 0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            if (!(bus.sram_en === 1'b1 && bus.sram_wmode === 1'b1 && bus.sram_addr === ADDR_W'(i) &&
                  bus.sram_wdata === '0 && bus.sram_wmask === 8'hFF && bus.init_done === 1'b0 &&
                  bus.req0_ready === 1'b0 && bus.req1_ready === 1'b0)) bad++;
            tick();
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL sweep_writes: got %0d bad cycles want 0", bad); end
        @(negedge clock);
        n_cmp++; if (bus.init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_1025: got %b want 1", bus.init_done); end
        tick();
    endtask

    task automatic test_sweep_reads;
        logic [ADDR_W-1:0] addrs [3];
        addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 0, addrs[k], '0, '0);
            @(negedge clock);
            n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL zrd_ready %0d: got %b want 1", addrs[k], bus.req0_ready); end
            tick();
            idle();
            @(negedge clock);
            n_cmp++; if (bus.resp0_valid !== 1'b1 || bus.resp_rdata !== '0) begin
                n_bad++; $display("FAIL zrd_data %0d: got v=%b d=%h want v=1 d=0", addrs[k], bus.resp0_valid, bus.resp_rdata); end
            tick();
        end
    endtask

    task automatic test_single_read;
        set_req(0, 1, 10'h155, PAT_A, 8'hFF);
        @(negedge clock);
        n_cmp++; if (bus.req0_ready !== 1'b1 || bus.sram_wmode !== 1'b1 || bus.sram_addr !== 10'h155) begin
            n_bad++; $display("FAIL wr_pins: got r=%b w=%b a=%h want r=1 w=1 a=155", bus.req0_ready, bus.sram_wmode, bus.sram_addr); end
        tick();
        set_req(0, 0, 10'h155, '0, '0);
        @(negedge clock);
        n_cmp++; if (bus.req0_ready !== 1'b1 || bus.resp0_valid !== 1'b0) begin
            n_bad++; $display("FAIL rd_accept: got r=%b resp=%b want r=1 resp=0", bus.req0_ready, bus.resp0_valid); end
        tick();
        idle();
        @(negedge clock);
        n_cmp++; if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0 || bus.resp_rdata !== PAT_A) begin
            n_bad++; $display("FAIL rd_t1: got v0=%b v1=%b d=%h want v0=1 v1=0 d=%h", bus.resp0_valid, bus.resp1_valid, bus.resp_rdata, PAT_A); end
        tick();
        @(negedge clock);
        n_cmp++; if (bus.resp0_valid !== 1'b0) begin n_bad++; $display("FAIL rd_t2: got v0=%b want 0", bus.resp0_valid); end
        tick();
    endtask

    task automatic test_contention;
        logic [1:0] exp_gnt, exp_rsp;
        logic [DATA_W-1:0] exp_d;
        int g;
        set_req(1, 1, 10'h020, PAT_C, 8'hFF);
        @(negedge clock);
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            n_bad++; $display("FAIL probe_wr: got %b want 10", {bus.req1_ready, bus.req0_ready}); end
        tick();
        set_req(0, 0, 10'h155, '0, '0);
        set_req(1, 0, 10'h020, '0, '0);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) idle();
            @(negedge clock);
            g = k % 2;
            exp_gnt = (k == 6) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
            exp_rsp = (k == 0) ? 2'b00 : (g == 1 ? 2'b01 : 2'b10);
            exp_d   = (g == 1) ? PAT_A : PAT_C;
            n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== exp_gnt) begin
                n_bad++; $display("FAIL cont_gnt %0d: got %b want %b", k, {bus.req1_ready, bus.req0_ready}, exp_gnt); end
            n_cmp++; if ({bus.resp1_valid, bus.resp0_valid} !== exp_rsp || (k > 0 && bus.resp_rdata !== exp_d)) begin
                n_bad++; $display("FAIL cont_rsp %0d: got %b d=%h want %b d=%h", k, {bus.resp1_valid, bus.resp0_valid}, bus.resp_rdata, exp_rsp, exp_d); end
            tick();
        end
    endtask

    task automatic test_masked_write;
        set_req(0, 1, 10'd7, ONES, 8'hFF);
        @(negedge clock);
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL mw_ones: got %b want 1", bus.req0_ready); end
        tick();
        set_req(0, 1, 10'd7, '0, 8'h01);
        @(negedge clock);
        n_cmp++; if (bus.req0_ready !== 1'b1 || bus.sram_wmask !== 8'h01) begin
            n_bad++; $display("FAIL mw_mask: got r=%b m=%h want r=1 m=01", bus.req0_ready, bus.sram_wmask); end
        tick();
        set_req(0, 0, 10'd7, '0, '0);
        @(negedge clock);
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL mw_rd: got %b want 1", bus.req0_ready); end
        tick();
        idle();
        set_req(1, 0, 10'h155, '0, '0);
        @(negedge clock);
        n_cmp++; if (bus.req1_ready !== 1'b1 || bus.resp0_valid !== 1'b1 || bus.resp_rdata !== MASKED) begin
            n_bad++; $display("FAIL mw_data: got r1=%b v0=%b d=%h want r1=1 v0=1 d=%h", bus.req1_ready, bus.resp0_valid, bus.resp_rdata, MASKED); end
        tick();
        idle();
        @(negedge clock);
        n_cmp++; if (bus.resp1_valid !== 1'b1 || bus.resp0_valid !== 1'b0 || bus.resp_rdata !== PAT_A) begin
            n_bad++; $display("FAIL b2b_rsp1: got v1=%b v0=%b d=%h want v1=1 v0=0 d=%h", bus.resp1_valid, bus.resp0_valid, bus.resp_rdata, PAT_A); end
        tick();
    endtask

    task automatic test_reset_mid_run;
        set_req(0, 0, 10'h155, '0, '0);
        @(negedge clock);
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL mr_ready: got %b want 1", bus.req0_ready); end
        #1 reset = 1;
        #1;
        n_cmp++; if (bus.req0_ready !== 1'b0 || bus.init_done !== 1'b0) begin
            n_bad++; $display("FAIL mr_drop: got r0=%b done=%b want 0 0", bus.req0_ready, bus.init_done); end
        tick();
        n_cmp++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin
            n_bad++; $display("FAIL mr_noresp: got %b want 00", {bus.resp1_valid, bus.resp0_valid}); end
        idle();
    endtask

    task automatic test_init_requests;
        int bad;
        set_req(1, 0, 10'h155, '0, '0);
        tick();
        reset = 0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus.sram_addr !== ADDR_W'(i) || bus.req1_ready !== 1'b0) bad++;
            tick();
        end
        @(negedge clock);
        n_cmp++; if (bad !== 0 || bus.sram_addr !== 10'd300) begin
            n_bad++; $display("FAIL ms_pre: got bad=%0d a=%0d want 0 300", bad, bus.sram_addr); end
        #1 reset = 1;
        #1;
        n_cmp++; if (bus.req1_ready !== 1'b0 || bus.init_done !== 1'b0 || bus.resp1_valid !== 1'b0 || bus.sram_addr !== '0) begin
            n_bad++; $display("FAIL ms_rst: got r1=%b done=%b v1=%b a=%0d want 0 0 0 0", bus.req1_ready, bus.init_done, bus.resp1_valid, bus.sram_addr); end
        tick();
        reset = 0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            if (bus.sram_addr !== ADDR_W'(i) || bus.sram_en !== 1'b1 || bus.sram_wmode !== 1'b1 ||
                bus.req1_ready !== 1'b0 || bus.init_done !== 1'b0) bad++;
            tick();
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL ms_sweep: got %0d bad cycles want 0", bad); end
        @(negedge clock);
        n_cmp++; if (bus.init_done !== 1'b1 || bus.req1_ready !== 1'b1 || bus.sram_addr !== 10'h155 || bus.sram_wmode !== 1'b0) begin
            n_bad++; $display("FAIL ms_first_gnt: got done=%b r1=%b a=%h w=%b want 1 1 155 0", bus.init_done, bus.req1_ready, bus.sram_addr, bus.sram_wmode); end
        tick();
        idle();
        @(negedge clock);
        n_cmp++; if (bus.resp1_valid !== 1'b1 || bus.resp_rdata !== '0) begin
            n_bad++; $display("FAIL ms_zero: got v1=%b d=%h want 1 0", bus.resp1_valid, bus.resp_rdata); end
        tick();
    endtask

    initial begin
        bus.sram_rdata = '0;
        test_reset();
        test_sweep_reads();
        test_single_read();
        test_contention();
        test_masked_write();
        test_reset_mid_run();
        test_init_requests();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
